symbol_sequencer: RTL

Sequencing controller for the compression front end. It accepts 32-bit bitstream words over a valid/ready handshake and splits each word into four bytes using a `bit_parser` instance. It then issues those bytes one per cycle as 8-bit symbols to the downstream frequency-count / Huffman stage. It also tracks frame boundaries and keeps word and symbol statistics for the host.

---
 rtl/compress_pkg.sv | 17 +
 rtl/bit_parser.sv | 17 +
 rtl/symbol_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/compress_pkg.sv
// Shared types and sizing for the compression front end.
// Combinational definitions only: no latency, no flow control.
package compress_pkg;

  localparam int WORD_W        = 32;
  localparam int SYM_W         = 8;
  localparam int SYMS_PER_WORD = 4;
  localparam int IDX_W         = $clog2(SYMS_PER_WORD);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMS_PER_WORD - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } seq_state_e;

endpackage

// File: rtl/bit_parser.sv
// Splits a bitstream word into its bytes, byte k = bits [8k+7:8k].
// Purely combinational: zero latency, no backpressure.
module bit_parser
  import compress_pkg::*;
(
  input  logic [WORD_W-1:0]                  i_word,
  output logic [SYMS_PER_WORD-1:0][SYM_W-1:0] o_bytes
);

  always_comb begin
    o_bytes = '0;
    for (int k = 0; k < SYMS_PER_WORD; k++) begin
      o_bytes[k] = i_word[k*SYM_W +: SYM_W];
    end
  end

endmodule

// File: rtl/symbol_sequencer.sv
// Issues each accepted 32-bit word as four 8-bit symbols, one per cycle; first symbol 1 cycle after accept.
// Downstream stalls hold the current symbol; in_ready is combinational on sym_ready for bubble-free streaming.
module symbol_sequencer
  import compress_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic [SYM_W-1:0]  sym_data,
  output logic              sym_last,
  output logic              frame_done,
  input  logic              clear,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  sym_count
);

  seq_state_e        r_state;
  logic [WORD_W-1:0] r_word;
  logic              r_last;
  logic [IDX_W-1:0]  r_idx;
  logic              r_sym_valid;
  logic [SYM_W-1:0]  r_sym_data;
  logic              r_sym_last;
  logic              r_frame_done;
  logic [CNT_W-1:0]  r_word_count;
  logic [CNT_W-1:0]  r_sym_count;

  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_sym_fire;
  seq_state_e        w_nxt_state;
  logic [WORD_W-1:0] w_nxt_word;
  logic              w_nxt_last;
  logic [IDX_W-1:0]  w_nxt_idx;
  logic [IDX_W-1:0]  w_nxt_sel;
  logic [SYM_W-1:0]  w_nxt_byte;
  logic [SYMS_PER_WORD-1:0][SYM_W-1:0] w_bytes;

  // Held low through reset so nothing is accepted before the FSM is known.
  assign w_in_ready = rst_n & ((r_state == ST_IDLE) |
                               ((r_state == ST_BUSY) & (r_idx == LAST_IDX) & sym_ready));
  assign w_in_fire  = in_valid & w_in_ready;
  assign w_sym_fire = r_sym_valid & sym_ready;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_word  = r_word;
    w_nxt_last  = r_last;
    w_nxt_idx   = r_idx;
    if (w_in_fire) begin
      w_nxt_state = ST_BUSY;
      w_nxt_word  = in_data;
      w_nxt_last  = in_last;
      w_nxt_idx   = '0;
    end else if (w_sym_fire) begin
      if (r_idx == LAST_IDX) begin
        w_nxt_state = ST_IDLE;
      end else begin
        w_nxt_idx = r_idx + 1'b1;
      end
    end
  end

  // Parse the word that will be held next cycle so the symbol can be registered.
  bit_parser u_bit_parser (
    .i_word  (w_nxt_word),
    .o_bytes (w_bytes)
  );

  assign w_nxt_sel  = MSB_FIRST ? (LAST_IDX - w_nxt_idx) : w_nxt_idx;
  assign w_nxt_byte = w_bytes[w_nxt_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_word       <= '0;
      r_last       <= 1'b0;
      r_idx        <= '0;
      r_sym_valid  <= 1'b0;
      r_sym_data   <= '0;
      r_sym_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_word       <= w_nxt_word;
      r_last       <= w_nxt_last;
      r_idx        <= w_nxt_idx;
      r_sym_valid  <= (w_nxt_state == ST_BUSY);
      if (w_nxt_state == ST_BUSY) begin
        r_sym_data <= w_nxt_byte;
      end
      r_sym_last   <= (w_nxt_state == ST_BUSY) & w_nxt_last & (w_nxt_idx == LAST_IDX);
      r_frame_done <= w_sym_fire & r_sym_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_count <= '0;
      r_sym_count  <= '0;
    end else if (clear) begin
      r_word_count <= '0;
      r_sym_count  <= '0;
    end else begin
      if (w_in_fire) begin
        r_word_count <= r_word_count + 1'b1;
      end
      if (w_sym_fire) begin
        r_sym_count <= r_sym_count + 1'b1;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign sym_valid  = r_sym_valid;
  assign sym_data   = r_sym_data;
  assign sym_last   = r_sym_last;
  assign frame_done = r_frame_done;
  assign word_count = r_word_count;
  assign sym_count  = r_sym_count;

endmodule
